// File: rtl/tube_event_readout.sv
// Drift-tube event readout: captures first-hit times in a window after a scintillator
// coincidence, then writes a framed event to the FIFO. Define ZERO_SUPPRESS_EN to skip unhit channels.
module tube_event_readout #(
  parameter int NCH       = 32,
  parameter int DATA_W    = 16,
  parameter int WINDOW    = 255,
  parameter int CLEAR_CYC = 11
) (
  input  logic              clk100,
  input  logic              rst,
  input  logic              scin_coin,
  input  logic [NCH-1:0]    tube_in,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fifo_wr_en,
  input  logic              fifo_full,
  output logic              busy,
  output logic [15:0]       dropped
);
  localparam int TIME_W = DATA_W - 8;
  localparam int CIW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CCW    = $clog2(CLEAR_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WINDOW, S_HEADER, S_CHAN, S_TRAILER, S_CLEAR
  } state_t;

  state_t            state, state_nx;
  logic [2:0]        scin_sync;
  logic [NCH-1:0]    tube_s1, tube_s2, tube_s3;
  logic              scin_edge;
  logic [NCH-1:0]    tube_edge;
  logic [NCH-1:0]    hit;
  logic [TIME_W-1:0] hit_time [NCH];
  logic [TIME_W-1:0] tcnt;
  logic [DATA_W-3:0] evt_num, nhit;
  logic [CCW-1:0]    ccnt;
  logic [CIW-1:0]    cur;
  logic              pending, last_ch, no_hits;

  assign scin_edge = scin_sync[1] & ~scin_sync[2];
  assign tube_edge = tube_s2 & ~tube_s3;

`ifdef ZERO_SUPPRESS_EN
  // Lowest pending hit is always the current channel; emitted flags are cleared, so skips cost nothing.
  always_comb begin
    cur = '0;
    for (int c = NCH - 1; c >= 0; c--)
      if (hit[c]) cur = CIW'(c);
  end
  assign last_ch = ((hit & ~(NCH'(1) << cur)) == '0);
  assign no_hits = (hit == '0);
`else
  logic [CIW-1:0] ch;
  assign cur     = ch;
  assign last_ch = (ch == CIW'(NCH - 1));
  assign no_hits = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    pending  = 1'b0;
    fifo_din = '0;
    unique case (state)
      S_IDLE:   if (scin_edge) state_nx = S_WINDOW;
      S_WINDOW: if (tcnt == TIME_W'(WINDOW - 1)) state_nx = S_HEADER;
      S_HEADER: begin
        pending  = 1'b1;
        fifo_din = {2'b10, evt_num};
        if (!fifo_full) state_nx = no_hits ? S_TRAILER : S_CHAN;
      end
      S_CHAN: begin
        pending  = 1'b1;
        fifo_din = {2'b01, 6'(cur), (hit[cur] ? hit_time[cur] : {TIME_W{1'b1}})};
        if (!fifo_full && last_ch) state_nx = S_TRAILER;
      end
      S_TRAILER: begin
        pending  = 1'b1;
        fifo_din = {2'b11, nhit};
        if (!fifo_full) state_nx = S_CLEAR;
      end
      S_CLEAR:  if (ccnt == CCW'(CLEAR_CYC - 1)) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign fifo_wr_en = pending && !fifo_full;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk100) begin
    if (rst) begin
      state     <= S_IDLE;
      scin_sync <= '0;
      tube_s1   <= '0;
      tube_s2   <= '0;
      tube_s3   <= '0;
      hit       <= '0;
      tcnt      <= '0;
      evt_num   <= '0;
      nhit      <= '0;
      ccnt      <= '0;
      dropped   <= '0;
`ifndef ZERO_SUPPRESS_EN
      ch        <= '0;
`endif
      for (int c = 0; c < NCH; c++) hit_time[c] <= '0;
    end else begin
      state     <= state_nx;
      scin_sync <= {scin_sync[1:0], scin_coin};
      tube_s1   <= tube_in;
      tube_s2   <= tube_s1;
      tube_s3   <= tube_s2;
      if (scin_edge && state != S_IDLE && dropped != 16'hFFFF)
        dropped <= dropped + 1'b1;
      // Bookkeeping per state; the write-phase states only move on an accepted word.
      unique case (state)
        S_IDLE: tcnt <= '0;
        S_WINDOW: begin
          tcnt <= tcnt + 1'b1;
          for (int c = 0; c < NCH; c++)
            if (tube_edge[c] && !hit[c]) begin
              hit[c]      <= 1'b1;
              hit_time[c] <= tcnt;
            end
        end
        S_HEADER: if (fifo_wr_en) begin
          evt_num <= evt_num + 1'b1;
`ifndef ZERO_SUPPRESS_EN
          ch      <= '0;
`endif
        end
        S_CHAN: if (fifo_wr_en) begin
          nhit <= nhit + 1'b1;
`ifdef ZERO_SUPPRESS_EN
          hit[cur] <= 1'b0;
`else
          ch <= ch + 1'b1;
`endif
        end
        S_TRAILER: if (fifo_wr_en) ccnt <= '0;
        S_CLEAR: begin
          ccnt <= ccnt + 1'b1;
          hit  <= '0;
          tcnt <= '0;
          nhit <= '0;
          for (int c = 0; c < NCH; c++) hit_time[c] <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tube_event_readout.sv
// Self-checking bench for tube_event_readout: expected FIFO words come from an event-level
// model (first hit per channel relative to the scintillator pin), plus literal frame checks.
module tb_tube_event_readout;
  localparam int NCH    = 32;
  localparam int DATA_W = 16;
  localparam int WINDOW = 255;
`ifdef ZERO_SUPPRESS_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic              clk100, rst, scin_coin, fifo_full;
  logic [NCH-1:0]    tube_in;
  logic [DATA_W-1:0] fifo_din;
  logic              fifo_wr_en, busy;
  logic [15:0]       dropped;

  tube_event_readout #(.NCH(NCH), .DATA_W(DATA_W), .WINDOW(WINDOW), .CLEAR_CYC(11)) dut (
    .clk100(clk100), .rst(rst), .scin_coin(scin_coin), .tube_in(tube_in),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
    .busy(busy), .dropped(dropped)
  );

  initial begin
    clk100 = 1'b0;
    forever #5 clk100 = ~clk100;
  end

  int vectors = 0;
  int miscompares = 0;
  int model_evt = 0;
  int exp_dropped = 0;
  int exp_words = 0;
  int pulse_ch[$];
  int pulse_off[$];
  int scin_extra[$];
  logic [15:0] expq[$];
  logic [15:0] wlog[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Any write must be accepted by a non-full FIFO and match the next modelled word.
  always @(negedge clk100) begin
    if (fifo_wr_en === 1'b1) begin
      checkOutput("write_while_full", {31'b0, fifo_full}, 32'h0);
      wlog.push_back(fifo_din);
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_write actual=%h required=none", fifo_din);
      end else begin
        checkOutput("fifo_din", {16'b0, fifo_din}, {16'b0, expq.pop_front()});
      end
    end
  end

  function automatic int firstTime(input int c);
    int best = -1;
    for (int i = 0; i < pulse_ch.size(); i++)
      if (pulse_ch[i] == c && pulse_off[i] >= 1 && pulse_off[i] <= WINDOW)
        if (best < 0 || pulse_off[i] - 1 < best) best = pulse_off[i] - 1;
    return best;
  endfunction

  function automatic logic [15:0] logWord(input int i);
    if (i < wlog.size()) return wlog[i];
    return 16'hxxxx;
  endfunction

  function automatic logic [NCH-1:0] tubeLevels(input int t);
    logic [NCH-1:0] v;
    v = '0;
    for (int i = 0; i < pulse_ch.size(); i++)
      if (t == pulse_off[i] || t == pulse_off[i] + 1) v[pulse_ch[i]] = 1'b1;
    return v;
  endfunction

  function automatic logic scinLevel(input int t);
    logic v;
    v = (t < 2);
    for (int i = 0; i < scin_extra.size(); i++)
      if (t == scin_extra[i] || t == scin_extra[i] + 1) v = 1'b1;
    return v;
  endfunction

  task automatic newEvent();
    pulse_ch.delete();
    pulse_off.delete();
    scin_extra.delete();
    wlog.delete();
  endtask

  task automatic addPulse(input int c, input int off);
    pulse_ch.push_back(c);
    pulse_off.push_back(off);
  endtask

  // Event-level model: header, one word per (hit) channel, trailer with the word count.
  task automatic buildEvent();
    int nh = 0;
    int ft;
    expq.push_back({2'b10, 14'(model_evt)});
    for (int c = 0; c < NCH; c++) begin
      ft = firstTime(c);
      if (ft >= 0) begin
        expq.push_back({2'b01, 6'(c), 8'(ft)});
        nh++;
      end else if (!ZS) begin
        expq.push_back({2'b01, 6'(c), 8'hFF});
        nh++;
      end
    end
    expq.push_back({2'b11, 14'(nh)});
    exp_words = expq.size();
    model_evt++;
    exp_dropped += scin_extra.size();
  endtask

  // Offsets are cycles after the scintillator pin rises; inputs change just after a rising edge.
  task automatic applyStimulus(input int rst_at, input int stall_at, input int stall_len);
    int t = 0;
    int last_stim = 5;
    logic [15:0] held = '0;
    foreach (pulse_off[i]) if (pulse_off[i] + 2 > last_stim) last_stim = pulse_off[i] + 2;
    foreach (scin_extra[i]) if (scin_extra[i] + 2 > last_stim) last_stim = scin_extra[i] + 2;
    if (rst_at + 1 > last_stim) last_stim = rst_at + 1;
    if (stall_at + stall_len > last_stim) last_stim = stall_at + stall_len;
    forever begin
      scin_coin = scinLevel(t);
      tube_in   = tubeLevels(t);
      fifo_full = (t >= stall_at && t < stall_at + stall_len);
      rst       = (t == rst_at);
      #3;
      if (fifo_full) begin
        if (t == stall_at) held = fifo_din;
        else checkOutput("stall_din", {16'b0, fifo_din}, {16'b0, held});
        checkOutput("stall_wr_en", {31'b0, fifo_wr_en}, 32'h0);
      end
      @(posedge clk100);
      #1;
      if (t == rst_at) begin
        expq.delete();
        checkOutput("rst_busy", {31'b0, busy}, 32'h0);
        checkOutput("rst_wr_en", {31'b0, fifo_wr_en}, 32'h0);
      end
      t++;
      if (t > last_stim && !busy) break;
      if (t > 4000) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL event_timeout actual=busy required=idle");
        break;
      end
    end
    scin_coin = 1'b0;
    tube_in   = '0;
    fifo_full = 1'b0;
    rst       = 1'b0;
    repeat (2) @(posedge clk100);
    #1;
  endtask

  task automatic checkEvent(input string tag);
    checkOutput({tag, "_busy"}, {31'b0, busy}, 32'h0);
    checkOutput({tag, "_words_left"}, expq.size(), 32'h0);
    checkOutput({tag, "_word_count"}, wlog.size(), exp_words);
    checkOutput({tag, "_dropped"}, {16'b0, dropped}, exp_dropped);
  endtask

  initial begin
    rst = 1'b1;
    scin_coin = 1'b0;
    tube_in = '0;
    fifo_full = 1'b0;
    repeat (3) @(posedge clk100);
    #1;
    checkOutput("reset_fifo_din", {16'b0, fifo_din}, 32'h0);
    checkOutput("reset_wr_en", {31'b0, fifo_wr_en}, 32'h0);
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("reset_dropped", {16'b0, dropped}, 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk100);
    #1;

    $display("[TB] event A: tube 5 at tcnt 17");
    newEvent();
    addPulse(5, 18);
    buildEvent();
    applyStimulus(-1, -1, 0);
    checkEvent("A");
    checkOutput("A_header", {16'b0, logWord(0)}, 32'h8000);
`ifdef ZERO_SUPPRESS_EN
    checkOutput("A_ch5", {16'b0, logWord(1)}, 32'h4511);
    checkOutput("A_trailer", {16'b0, logWord(2)}, 32'hC001);
`else
    checkOutput("A_ch0", {16'b0, logWord(1)}, 32'h40FF);
    checkOutput("A_ch5", {16'b0, logWord(6)}, 32'h4511);
    checkOutput("A_trailer", {16'b0, logWord(33)}, 32'hC020);
`endif

    $display("[TB] event B: repeat pulse, window edges, FIFO stall");
    newEvent();
    addPulse(3, 11);
    addPulse(3, 41);
    addPulse(7, 255);
    addPulse(8, 256);
    addPulse(9, 0);
    addPulse(12, 100);
    buildEvent();
    applyStimulus(-1, 265, 20);
    checkEvent("B");
    checkOutput("B_header", {16'b0, logWord(0)}, 32'h8001);
`ifdef ZERO_SUPPRESS_EN
    checkOutput("B_ch3", {16'b0, logWord(1)}, 32'h430A);
    checkOutput("B_ch7", {16'b0, logWord(2)}, 32'h47FE);
    checkOutput("B_ch12", {16'b0, logWord(3)}, 32'h4C63);
    checkOutput("B_trailer", {16'b0, logWord(4)}, 32'hC003);
`else
    checkOutput("B_ch3", {16'b0, logWord(4)}, 32'h430A);
    checkOutput("B_ch7", {16'b0, logWord(8)}, 32'h47FE);
    checkOutput("B_ch8", {16'b0, logWord(9)}, 32'h48FF);
    checkOutput("B_ch9", {16'b0, logWord(10)}, 32'h49FF);
    checkOutput("B_ch12", {16'b0, logWord(13)}, 32'h4C63);
    checkOutput("B_trailer", {16'b0, logWord(33)}, 32'hC020);
`endif

    $display("[TB] event C: hits on ch0 and ch31, three coincidences while busy");
    newEvent();
    addPulse(0, 3);
    addPulse(31, 200);
    scin_extra.push_back(50);
    scin_extra.push_back(120);
`ifdef ZERO_SUPPRESS_EN
    scin_extra.push_back(265);
`else
    scin_extra.push_back(295);
`endif
    buildEvent();
    applyStimulus(-1, -1, 0);
    checkEvent("C");
    checkOutput("C_dropped3", {16'b0, dropped}, 32'd3);
    checkOutput("C_header", {16'b0, logWord(0)}, 32'h8002);
    checkOutput("C_ch0", {16'b0, logWord(1)}, 32'h4002);
`ifdef ZERO_SUPPRESS_EN
    checkOutput("C_ch31", {16'b0, logWord(2)}, 32'h5FC7);
    checkOutput("C_trailer", {16'b0, logWord(3)}, 32'hC002);
    checkOutput("C_writes", wlog.size(), 32'd4);
`else
    checkOutput("C_ch31", {16'b0, logWord(32)}, 32'h5FC7);
    checkOutput("C_trailer", {16'b0, logWord(33)}, 32'hC020);
`endif

    $display("[TB] event D: reset during channel readout");
    newEvent();
    addPulse(1, 20);
    buildEvent();
    applyStimulus(259, -1, 0);
    model_evt = 0;
    exp_dropped = 0;
    checkOutput("D_writes", wlog.size(), 32'd2);
    checkOutput("D_busy", {31'b0, busy}, 32'h0);
    checkOutput("D_dropped", {16'b0, dropped}, 32'h0);

    $display("[TB] event E: first window cycle after reset");
    newEvent();
    addPulse(2, 1);
    buildEvent();
    applyStimulus(-1, -1, 0);
    checkEvent("E");
    checkOutput("E_header", {16'b0, logWord(0)}, 32'h8000);
`ifdef ZERO_SUPPRESS_EN
    checkOutput("E_ch2", {16'b0, logWord(1)}, 32'h4200);
`else
    checkOutput("E_ch2", {16'b0, logWord(3)}, 32'h4200);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
